// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one fully pipelined FP adder among NUM_REQ requesters.
// A {valid, index} tag shadows the adder pipeline so each result is routed back to its owner.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     add_sub_in,
  input  logic [32*NUM_REQ-1:0]  dataa_in,
  input  logic [32*NUM_REQ-1:0]  datab_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [31:0]            result,
  output logic                   fp_clk_en,
  output logic                   fp_add_sub,
  output logic [31:0]            fp_dataa,
  output logic [31:0]            fp_datab,
  input  logic [31:0]            fp_result
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             vld_q [LATENCY];
  logic             vld_d [LATENCY];
  logic [IDX_W-1:0] idx_q [LATENCY];
  logic [IDX_W-1:0] idx_d [LATENCY];

  logic             found;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W:0]   scan;

  // Scan ptr, ptr+1, ... with wrap; scan is one bit wider so the sum never overflows.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (scan >= (IDX_W+1)'(NUM_REQ)) scan = scan - (IDX_W+1)'(NUM_REQ);
      if (!found && req[scan[IDX_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = scan[IDX_W-1:0];
      end
    end
    if (reset) found = 1'b0;
  end

  always_comb begin
    grant      = '0;
    fp_add_sub = 1'b0;
    fp_dataa   = '0;
    fp_datab   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && gnt_idx == IDX_W'(i)) begin
        grant[i]   = 1'b1;
        fp_add_sub = add_sub_in[i];
        fp_dataa   = dataa_in[32*i +: 32];
        fp_datab   = datab_in[32*i +: 32];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) ptr_d = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
    vld_d[0] = found;
    idx_d[0] = gnt_idx;
    for (int j = 1; j < LATENCY; j++) begin
      vld_d[j] = vld_q[j-1];
      idx_d[j] = idx_q[j-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
      for (int j = 0; j < LATENCY; j++) begin
        vld_q[j] <= 1'b0;
        idx_q[j] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int j = 0; j < LATENCY; j++) begin
        vld_q[j] <= vld_d[j];
        idx_q[j] <= idx_d[j];
      end
    end
  end

  // Tags already in flight are only cleared at the reset edge, so mask done meanwhile.
  always_comb begin
    done = '0;
    for (int i = 0; i < NUM_REQ; i++)
      done[i] = !reset && vld_q[LATENCY-1] && (idx_q[LATENCY-1] == IDX_W'(i));
  end

  assign result    = fp_result;
  assign fp_clk_en = ~reset;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: behavioural FP adder pipeline, queue-based scoreboard and
// round-robin reference model, driven by directed scenarios and random request traffic.
module tb_fp_add_arbiter;
  localparam int N   = 4;
  localparam int LAT = 7;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req, add_sub_in, grant, done;
  logic [32*N-1:0] dataa_in, datab_in;
  logic [31:0]     result, fp_dataa, fp_datab, fp_result;
  logic            fp_clk_en, fp_add_sub;

  always #5 clock = ~clock;

  fp_add_arbiter #(.NUM_REQ(N), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .req(req), .add_sub_in(add_sub_in),
    .dataa_in(dataa_in), .datab_in(datab_in), .grant(grant), .done(done),
    .result(result), .fp_clk_en(fp_clk_en), .fp_add_sub(fp_add_sub),
    .fp_dataa(fp_dataa), .fp_datab(fp_datab), .fp_result(fp_result)
  );

  function automatic real s2r(logic [31:0] a);
    logic [63:0] d;
    if (a[30:0] == 31'd0) return 0.0;
    d = {a[31], 11'(a[30:23]) - 11'd127 + 11'd1023, a[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd1023 + 11'd127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b, logic op);
    real ra, rb;
    ra = s2r(a);
    rb = s2r(b);
    return op ? r2s(ra + rb) : r2s(ra - rb);
  endfunction

  // Stand-in for the external adder: samples operands every edge, answers LAT cycles later.
  logic [31:0] pipe [LAT];
  always @(posedge clock) begin
    pipe[0] <= fadd(fp_dataa, fp_datab, fp_add_sub);
    for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
  end
  assign fp_result = pipe[LAT-1];

  typedef struct {
    bit          v;
    int          idx;
    logic [31:0] res;
  } ent_t;

  ent_t        sb[$];
  int          mptr;
  int          checks = 0;
  int          failures = 0;
  logic [N-1:0] g_seen, d_seen;
  logic [31:0]  r_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ent_t empty_ent();
    ent_t e;
    e.v = 1'b0; e.idx = 0; e.res = 32'd0;
    return e;
  endfunction

  // One cycle: compare outputs mid-cycle against the model, then advance past the next edge.
  task automatic step();
    ent_t        e;
    int          g;
    int          idx;
    logic [N-1:0] expg, expd;
    @(negedge clock);
    g_seen = grant;
    d_seen = done;
    r_seen = result;
    if (reset) begin
      check("rst_grant", grant, 0);
      check("rst_done", done, 0);
      check("rst_clk_en", fp_clk_en, 0);
      sb.delete();
      for (int j = 0; j < LAT; j++) sb.push_back(empty_ent());
      mptr = 0;
    end else begin
      check("clk_en", fp_clk_en, 1);
      e = sb.pop_front();
      expd = '0;
      if (e.v) expd[e.idx] = 1'b1;
      check("done", done, expd);
      if (e.v) check("result", result, e.res);
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && req[idx]) g = idx;
      end
      expg = '0;
      if (g >= 0) expg[g] = 1'b1;
      check("grant", grant, expg);
      if (g >= 0) begin
        check("fp_dataa", fp_dataa, dataa_in[32*g +: 32]);
        check("fp_datab", fp_datab, datab_in[32*g +: 32]);
        check("fp_add_sub", fp_add_sub, add_sub_in[g]);
        e.v = 1'b1; e.idx = g;
        e.res = fadd(dataa_in[32*g +: 32], datab_in[32*g +: 32], add_sub_in[g]);
        sb.push_back(e);
        mptr = (g + 1) % N;
      end else begin
        check("idle_dataa", fp_dataa, 0);
        check("idle_datab", fp_datab, 0);
        check("idle_add_sub", fp_add_sub, 0);
        sb.push_back(empty_ent());
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
    add_sub_in[i]       = op;
    dataa_in[32*i +: 32] = a;
    datab_in[32*i +: 32] = b;
  endtask

  task automatic rand_op(input int i);
    set_op(i, 1'($urandom_range(0, 1)), r2s(real'($urandom_range(1, 1000))),
           r2s(real'($urandom_range(1, 1000))));
  endtask

  task automatic run_single(input int i, input logic [31:0] exp_res);
    int t_g, t_d;
    t_g = -1;
    t_d = -1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (g_seen[i] && t_g < 0) begin
        t_g = c;
        req[i] = 1'b0;
      end
      if (d_seen[i]) begin
        t_d = c;
        check("single_result", r_seen, exp_res);
        break;
      end
    end
    check("single_latency", 32'(t_d - t_g), LAT);
  endtask

  initial begin
    int n1, n3, cnt;
    reset = 1'b1; req = '0; add_sub_in = '0; dataa_in = '0; datab_in = '0;
    @(posedge clock); #1;
    repeat (3) step();
    reset = 1'b0;

    set_op(2, 1'b1, 32'h3F800000, 32'h40000000);
    req[2] = 1'b1;
    run_single(2, 32'h40400000);

    set_op(0, 1'b0, 32'h40A00000, 32'h3F800000);
    req[0] = 1'b1;
    run_single(0, 32'h40800000);

    // All requesters held high straight out of reset.
    reset = 1'b1;
    step();
    for (int i = 0; i < N; i++) rand_op(i);
    req = '1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      check("rr_seq", g_seen, 32'(1 << (c % N)));
      if (c >= LAT && c < LAT + N) check("done_seq", d_seen, 32'(1 << (c - LAT)));
    end
    req = '0;
    repeat (LAT + 1) step();

    // Move ptr to 2, then contend with requesters 1 and 3.
    req = 4'b0010;
    step();
    req = 4'b1010;
    n1 = 0; n3 = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c == 0) check("fair_first", g_seen, 4'b1000);
      if (g_seen[1]) n1++;
      if (g_seen[3]) n3++;
    end
    check("fair_n1", n1, 10);
    check("fair_n3", n3, 10);
    req = '0;
    repeat (LAT + 1) step();

    // Reset while three ops are in flight.
    for (int i = 0; i < 3; i++) rand_op(i);
    req = 4'b0111;
    repeat (3) begin
      step();
      req = req & ~g_seen;
    end
    check("flight_issued", req, 0);
    cnt = 0;
    repeat (4) begin
      step();
      if (|d_seen) cnt++;
    end
    reset = 1'b1;
    step();
    if (|d_seen) cnt++;
    reset = 1'b0;
    repeat (15) begin
      step();
      if (|d_seen) cnt++;
    end
    check("flush_done", cnt, 0);

    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (|g_seen || |d_seen) cnt++;
    end
    check("idle_quiet", cnt, 0);

    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 149) == 0);
      step();
      for (int i = 0; i < N; i++) begin
        if (req[i] && g_seen[i]) req[i] = 1'b0;
        else if (req[i] && $urandom_range(0, 19) == 0) req[i] = 1'b0;
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          rand_op(i);
          req[i] = 1'b1;
        end
      end
    end
    reset = 1'b0;
    req = '0;
    repeat (LAT + 2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
